// File: rtl/multi_pulser_pkg.sv
// multi_pulser shared definitions: edge-mode codes, channel FSM
// state type and counter-width helpers. Optional: MULTI_PULSER_REPEAT_EN.
package multi_pulser_pkg;

    localparam int EDGE_RISING  = 0;
    localparam int EDGE_FALLING = 1;
    localparam int EDGE_BOTH    = 2;

`ifdef MULTI_PULSER_REPEAT_EN
    typedef enum logic [1:0] {
        IDLE,
        PULSING,
        REPEAT_WAIT
    } state_t;
`else
    typedef enum logic {
        IDLE,
        PULSING
    } state_t;
`endif

    // bits needed to hold the values 0..n
    function automatic int cnt_w(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/multi_pulser_channel.sv
// pulser_channel: one channel's debounce, edge detect and pulse FSM
// (plus auto-repeat when MULTI_PULSER_REPEAT_EN is defined).
// Ports: clock, reset (sync, active high), trigger, clear_overrun
// in; pulse, level, overrun out (all registered).
module pulser_channel
    import multi_pulser_pkg::*;
#(
    parameter int DEBOUNCE      = 4,
    parameter int PULSE_WIDTH   = 1,
`ifdef MULTI_PULSER_REPEAT_EN
    parameter int REPEAT_DELAY  = 1000,
    parameter int REPEAT_PERIOD = 250,
`endif
    parameter int EDGE_MODE     = EDGE_RISING
) (
    input  logic clock,
    input  logic reset,
    input  logic trigger,
    input  logic clear_overrun,
    output logic pulse,
    output logic level,
    output logic overrun
);

    localparam int DW = cnt_w(DEBOUNCE);
    localparam int PW = cnt_w(PULSE_WIDTH);

    localparam logic [DW-1:0] DLAST = DW'(DEBOUNCE - 1);
    localparam logic [PW-1:0] PLAST = PW'(PULSE_WIDTH - 1);

    // level value that counts as "pressed" for the repeat logic
    localparam logic ACT = (EDGE_MODE == EDGE_FALLING) ? 1'b0 : 1'b1;

`ifdef MULTI_PULSER_REPEAT_EN
    localparam int RW = cnt_w(max2(REPEAT_DELAY, REPEAT_PERIOD));
    localparam logic [RW-1:0] RFIRST = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] RNEXT  = RW'(REPEAT_PERIOD - 1);
    localparam bit REP_OK = (EDGE_MODE != EDGE_BOTH);
`endif

    logic [DW-1:0] dcnt_q;
    logic          level_q;
    logic          flip;
    logic          lvl_nx;
    logic          ev;

    // the sample that completes the run of DEBOUNCE differing samples
    assign flip   = (trigger != level_q) && (dcnt_q == DLAST);
    assign lvl_nx = level_q ^ flip;
    assign ev     = flip &&
                    (EDGE_MODE == EDGE_BOTH || lvl_nx == ACT);

    always_ff @(posedge clock) begin
        if (reset) begin
            dcnt_q  <= '0;
            level_q <= 1'b0;
        end else if (trigger == level_q) begin
            dcnt_q  <= '0;
        end else if (flip) begin
            dcnt_q  <= '0;
            level_q <= ~level_q;
        end else begin
            dcnt_q  <= dcnt_q + 1'b1;
        end
    end

    state_t        state_q, state_d;
    logic [PW-1:0] pcnt_q, pcnt_d;
    logic          pulse_q, pulse_d;
    logic          ovr_q, ovr_d;
`ifdef MULTI_PULSER_REPEAT_EN
    logic [RW-1:0] rcnt_q, rcnt_d;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            pcnt_q  <= '0;
            pulse_q <= 1'b0;
            ovr_q   <= 1'b0;
`ifdef MULTI_PULSER_REPEAT_EN
            rcnt_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            pcnt_q  <= pcnt_d;
            pulse_q <= pulse_d;
            ovr_q   <= ovr_d;
`ifdef MULTI_PULSER_REPEAT_EN
            rcnt_q  <= rcnt_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        pcnt_d  = pcnt_q;
        pulse_d = pulse_q;
        ovr_d   = ovr_q & ~clear_overrun;
`ifdef MULTI_PULSER_REPEAT_EN
        // rcnt runs from each pulse start, so the
        // repeat spacing is measured start to start
        rcnt_d  = rcnt_q - RW'(rcnt_q != '0);
`endif
        unique case (state_q)
            IDLE: begin
                if (ev) begin
                    state_d = PULSING;
                    pulse_d = 1'b1;
                    pcnt_d  = PLAST;
`ifdef MULTI_PULSER_REPEAT_EN
                    rcnt_d  = RFIRST;
`endif
                end
            end
            PULSING: begin
                if (ev)
                    ovr_d = 1'b1;
                if (pcnt_q != '0) begin
                    pcnt_d = pcnt_q - 1'b1;
                end else begin
                    pulse_d = 1'b0;
                    state_d = IDLE;
`ifdef MULTI_PULSER_REPEAT_EN
                    if (REP_OK && lvl_nx == ACT)
                        state_d = REPEAT_WAIT;
`endif
                end
            end
`ifdef MULTI_PULSER_REPEAT_EN
            REPEAT_WAIT: begin
                if (ev) begin
                    state_d = PULSING;
                    pulse_d = 1'b1;
                    pcnt_d  = PLAST;
                    rcnt_d  = RFIRST;
                end else if (lvl_nx != ACT) begin
                    state_d = IDLE;
                end else if (rcnt_q == '0) begin
                    state_d = PULSING;
                    pulse_d = 1'b1;
                    pcnt_d  = PLAST;
                    rcnt_d  = RNEXT;
                end
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    assign pulse   = pulse_q;
    assign level   = level_q;
    assign overrun = ovr_q;

endmodule

// File: rtl/multi_pulser.sv
// multi_pulser: NUM_CH independent debounced one-shot pulsers.
// Ports: clock, reset (sync, active high), trigger[NUM_CH],
// clear_overrun[NUM_CH] in; pulse, level, overrun[NUM_CH] out.
// Optional auto-repeat: define MULTI_PULSER_REPEAT_EN.
module multi_pulser
    import multi_pulser_pkg::*;
#(
    parameter int NUM_CH        = 4,
    parameter int DEBOUNCE      = 4,
    parameter int PULSE_WIDTH   = 1,
    parameter int EDGE_MODE     = EDGE_RISING,
    parameter int REPEAT_DELAY  = 1000,
    parameter int REPEAT_PERIOD = 250
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [NUM_CH-1:0] trigger,
    input  logic [NUM_CH-1:0] clear_overrun,
    output logic [NUM_CH-1:0] pulse,
    output logic [NUM_CH-1:0] level,
    output logic [NUM_CH-1:0] overrun
);

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        pulser_channel #(
            .DEBOUNCE      (DEBOUNCE),
            .PULSE_WIDTH   (PULSE_WIDTH),
`ifdef MULTI_PULSER_REPEAT_EN
            .REPEAT_DELAY  (REPEAT_DELAY),
            .REPEAT_PERIOD (REPEAT_PERIOD),
`endif
            .EDGE_MODE     (EDGE_MODE)
        ) u_ch (
            .clock         (clock),
            .reset         (reset),
            .trigger       (trigger[i]),
            .clear_overrun (clear_overrun[i]),
            .pulse         (pulse[i]),
            .level         (level[i]),
            .overrun       (overrun[i])
        );
    end

endmodule

// File: tb/tb_multi_pulser.sv
// Bench for multi_pulser: several configurations side by side,
// driven from a vector table with a queue of expected outputs.
module tb_multi_pulser;

`ifdef MULTI_PULSER_REPEAT_EN
    localparam int NDUT = 6;
`else
    localparam int NDUT = 5;
`endif

    logic       clock;
    logic       rs [6];
    logic [1:0] tr [6];
    logic [1:0] cl [6];
    logic [1:0] po [6];
    logic [1:0] lo [6];
    logic [1:0] oo [6];

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // 0: DB4 PW1 rising   1: DB4 PW3 both   2: DB4 PW3 falling
    // 3: DB1 PW4 both     4: DB4 PW8 rising 5: repeat DB4 PW1
    multi_pulser #(.NUM_CH(2), .DEBOUNCE(4), .PULSE_WIDTH(1),
                   .EDGE_MODE(0)) u0 (
        .clock(clock), .reset(rs[0]), .trigger(tr[0]),
        .clear_overrun(cl[0]), .pulse(po[0]), .level(lo[0]),
        .overrun(oo[0]));
    multi_pulser #(.NUM_CH(2), .DEBOUNCE(4), .PULSE_WIDTH(3),
                   .EDGE_MODE(2)) u1 (
        .clock(clock), .reset(rs[1]), .trigger(tr[1]),
        .clear_overrun(cl[1]), .pulse(po[1]), .level(lo[1]),
        .overrun(oo[1]));
    multi_pulser #(.NUM_CH(2), .DEBOUNCE(4), .PULSE_WIDTH(3),
                   .EDGE_MODE(1)) u2 (
        .clock(clock), .reset(rs[2]), .trigger(tr[2]),
        .clear_overrun(cl[2]), .pulse(po[2]), .level(lo[2]),
        .overrun(oo[2]));
    multi_pulser #(.NUM_CH(2), .DEBOUNCE(1), .PULSE_WIDTH(4),
                   .EDGE_MODE(2)) u3 (
        .clock(clock), .reset(rs[3]), .trigger(tr[3]),
        .clear_overrun(cl[3]), .pulse(po[3]), .level(lo[3]),
        .overrun(oo[3]));
    multi_pulser #(.NUM_CH(2), .DEBOUNCE(4), .PULSE_WIDTH(8),
                   .EDGE_MODE(0)) u4 (
        .clock(clock), .reset(rs[4]), .trigger(tr[4]),
        .clear_overrun(cl[4]), .pulse(po[4]), .level(lo[4]),
        .overrun(oo[4]));
`ifdef MULTI_PULSER_REPEAT_EN
    multi_pulser #(.NUM_CH(2), .DEBOUNCE(4), .PULSE_WIDTH(1),
                   .EDGE_MODE(0), .REPEAT_DELAY(20),
                   .REPEAT_PERIOD(5)) u5 (
        .clock(clock), .reset(rs[5]), .trigger(tr[5]),
        .clear_overrun(cl[5]), .pulse(po[5]), .level(lo[5]),
        .overrun(oo[5]));
`else
    assign po[5] = 2'b00;
    assign lo[5] = 2'b00;
    assign oo[5] = 2'b00;
`endif

    typedef struct {
        int         dut;
        logic       rst;
        logic [1:0] trig;
        logic [1:0] clr;
        logic [1:0] ep;
        logic [1:0] el;
        logic [1:0] eo;
        int         n;
    } vec_t;

    typedef struct {
        int         dut;
        int         row;
        logic [1:0] p;
        logic [1:0] l;
        logic [1:0] o;
    } exp_t;

    vec_t tbl [$];
    exp_t sb  [$];
    int   n_cmp;
    int   n_bad;

    function automatic void add(int d, logic r, logic [1:0] t,
                                logic [1:0] c, logic [1:0] p,
                                logic [1:0] l, logic [1:0] o,
                                int n);
        vec_t v;
        v.dut = d; v.rst = r; v.trig = t; v.clr = c;
        v.ep = p; v.el = l; v.eo = o; v.n = n;
        tbl.push_back(v);
    endfunction

    task automatic check(string nm, int row, int d,
                         logic [1:0] got, logic [1:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s row%0d dut%0d got %b want %b",
                     nm, row, d, got, want);
        end
    endtask

    initial begin
        exp_t e;
        n_cmp = 0;
        n_bad = 0;

        // dut0: press, long hold, release, short glitch
        add(0, 0, 1, 0, 0, 0, 0, 3);
        add(0, 0, 1, 0, 1, 1, 0, 1);
        add(0, 0, 1, 0, 0, 1, 0, 16);
        add(0, 0, 0, 0, 0, 1, 0, 3);
        add(0, 0, 0, 0, 0, 0, 0, 3);
        add(0, 0, 1, 0, 0, 0, 0, 3);
        add(0, 0, 0, 0, 0, 0, 0, 5);
        // dut1: both edges, 3-cycle pulses
        add(1, 0, 1, 0, 0, 0, 0, 3);
        add(1, 0, 1, 0, 1, 1, 0, 3);
        add(1, 0, 1, 0, 0, 1, 0, 4);
        add(1, 0, 0, 0, 0, 1, 0, 3);
        add(1, 0, 0, 0, 1, 0, 0, 3);
        add(1, 0, 0, 0, 0, 0, 0, 3);
        // dut2: falling only
        add(2, 0, 1, 0, 0, 0, 0, 3);
        add(2, 0, 1, 0, 0, 1, 0, 7);
        add(2, 0, 0, 0, 0, 1, 0, 3);
        add(2, 0, 0, 0, 1, 0, 0, 3);
        add(2, 0, 0, 0, 0, 0, 0, 3);
        // dut3: overrun, clear alone, set beats clear
        add(3, 0, 1, 0, 1, 1, 0, 2);
        add(3, 0, 0, 0, 1, 0, 1, 2);
        add(3, 0, 0, 0, 0, 0, 1, 2);
        add(3, 0, 0, 1, 0, 0, 0, 1);
        add(3, 0, 0, 0, 0, 0, 0, 1);
        add(3, 0, 1, 0, 1, 1, 0, 1);
        add(3, 0, 0, 1, 1, 0, 1, 1);
        add(3, 0, 0, 0, 1, 0, 1, 2);
        add(3, 0, 0, 0, 0, 0, 1, 1);
        add(3, 0, 0, 1, 0, 0, 0, 1);
        // dut4: reset mid-pulse with trigger held through it
        add(4, 0, 1, 0, 0, 0, 0, 3);
        add(4, 0, 1, 0, 1, 1, 0, 3);
        add(4, 1, 1, 0, 0, 0, 0, 1);
        add(4, 0, 1, 0, 0, 0, 0, 3);
        add(4, 0, 1, 0, 1, 1, 0, 8);
        add(4, 0, 1, 0, 0, 1, 0, 2);
`ifdef MULTI_PULSER_REPEAT_EN
        // dut5: t0, t0+20, +25, +30, +35, then release
        add(5, 0, 1, 0, 0, 0, 0, 3);
        add(5, 0, 1, 0, 1, 1, 0, 1);
        add(5, 0, 1, 0, 0, 1, 0, 19);
        add(5, 0, 1, 0, 1, 1, 0, 1);
        add(5, 0, 1, 0, 0, 1, 0, 4);
        add(5, 0, 1, 0, 1, 1, 0, 1);
        add(5, 0, 1, 0, 0, 1, 0, 4);
        add(5, 0, 1, 0, 1, 1, 0, 1);
        add(5, 0, 1, 0, 0, 1, 0, 4);
        add(5, 0, 0, 0, 1, 1, 0, 1);
        add(5, 0, 0, 0, 0, 1, 0, 2);
        add(5, 0, 0, 0, 0, 0, 0, 8);
`endif

        for (int d = 0; d < 6; d++) begin
            rs[d] = 1'b1;
            tr[d] = 2'b00;
            cl[d] = 2'b00;
        end
        repeat (2) @(posedge clock);
        #1;
        for (int d = 0; d < NDUT; d++) begin
            check("rst_pulse", -1, d, po[d], 2'b00);
            check("rst_level", -1, d, lo[d], 2'b00);
            check("rst_ovr",   -1, d, oo[d], 2'b00);
        end
        @(negedge clock);
        for (int d = 0; d < 6; d++) rs[d] = 1'b0;

        for (int i = 0; i < tbl.size(); i++) begin
            for (int k = 0; k < tbl[i].n; k++) begin
                @(negedge clock);
                rs[tbl[i].dut] = tbl[i].rst;
                tr[tbl[i].dut] = tbl[i].trig;
                cl[tbl[i].dut] = tbl[i].clr;
                e.dut = tbl[i].dut;
                e.row = i;
                e.p   = tbl[i].ep;
                e.l   = tbl[i].el;
                e.o   = tbl[i].eo;
                sb.push_back(e);
                @(posedge clock);
                #1;
                e = sb.pop_front();
                check("pulse", e.row, e.dut, po[e.dut], e.p);
                check("level", e.row, e.dut, lo[e.dut], e.l);
                check("ovr",   e.row, e.dut, oo[e.dut], e.o);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/multi_pulser.md
Name: multi_pulser

Overview:
- Parametrised, multi-channel successor to the single-pulse generator.
- Each of NUM_CH asynchronous-quality trigger lines (buttons, switches, handshake strobes) is debounced and edge-detected per a selectable mode.
- Each detected edge produces a pulse of programmable width.
- Sits between board inputs and the communication/control FSMs, giving each consumer a clean, one-event-one-pulse strobe plus a debounced level.

Parameters:
- NUM_CH, 4: number of independent channels.
- DEBOUNCE, 4: consecutive identical samples required before the debounced level changes; must be >= 1.
- PULSE_WIDTH, 1: pulse length in clock cycles; must be >= 1.
- EDGE_MODE, 0: 0 = rising, 1 = falling, 2 = both edges; same for all channels.
- REPEAT_DELAY, 1000: cycles from the first pulse to the first auto-repeat pulse. Used only with the optional feature.
- REPEAT_PERIOD, 250: cycles between auto-repeat pulses; must be > PULSE_WIDTH. Used only with the optional feature.

Ports:
- clock  input  1  system clock; the only clock domain.
- reset  input  1  synchronous, active-high reset.
- trigger  input  NUM_CH  raw trigger lines, one per channel.
- clear_overrun  input  NUM_CH  per-channel synchronous clear of the overrun flag.
- pulse  output  NUM_CH  registered per-channel event pulse.
- level  output  NUM_CH  registered debounced trigger level.
- overrun  output  NUM_CH  sticky flag: an event was dropped because a pulse was still active.

Behaviour:
- Reset: pulse, level and overrun are all 0; all counters are 0.
- Reset overrides everything in the same cycle, including mid-pulse and mid-debounce.
- Trigger held high across reset release produces a rising event after DEBOUNCE cycles, exactly like a fresh press.
- Channels are fully independent. No cross-channel interaction.
- Debounce, per channel:
  - Counter dcnt, width $clog2(DEBOUNCE+1).
  - On each edge: if trigger == level, dcnt <= 0.
  - Otherwise dcnt increments. When the sample that would make dcnt == DEBOUNCE arrives, level toggles and dcnt <= 0.
  - Latency: trigger first sampled different at edge E and held through edge E+DEBOUNCE-1 gives level toggled after edge E+DEBOUNCE-1. With DEBOUNCE=1 this is one register delay.
  - Any glitch shorter than DEBOUNCE samples leaves level unchanged.
- Event: generated in the cycle level toggles, if the direction matches EDGE_MODE.
- Pulse FSM, per channel, states IDLE and PULSING; counter pcnt, width $clog2(PULSE_WIDTH+1).
  - IDLE + event -> PULSING: pulse=1, pcnt=PULSE_WIDTH-1. pulse rises in the same edge as level.
  - PULSING with pcnt != 0: pcnt decrements, pulse stays 1.
  - PULSING with pcnt == 0: -> IDLE, pulse=0.
  - Pulse is therefore high for exactly PULSE_WIDTH cycles.
  - Event in PULSING: the pulse is not extended or restarted; overrun <= 1.
- Overrun:
  - clear_overrun[i] clears overrun[i] on the next edge.
  - If set and clear occur in the same cycle, set wins.
- Hold: a trigger that stays held produces no further pulses (one event, one pulse).

Optional Feature:
- Macro MULTI_PULSER_REPEAT_EN.
- Defined, adds state REPEAT_WAIT and counter rcnt, width $clog2(max(REPEAT_DELAY,REPEAT_PERIOD)+1):
  - When a pulse completes and level is still at the active value (1 for rising, 0 for falling), enter REPEAT_WAIT.
  - rcnt counts so the next pulse starts REPEAT_DELAY cycles after the first pulse start. Later pulses start every REPEAT_PERIOD cycles while level holds.
  - Level leaving the active value aborts to IDLE immediately; an in-flight pulse finishes normally.
  - Repeat is disabled when EDGE_MODE=2.
  - Repeat pulses never set overrun.
- Undefined: REPEAT_WAIT, rcnt and the related logic are absent; REPEAT_DELAY and REPEAT_PERIOD are ignored.

Decomposition:
- Package multi_pulser_pkg:
  - EDGE_RISING=0, EDGE_FALLING=1, EDGE_BOTH=2.
  - State typedef {IDLE, PULSING, REPEAT_WAIT}.
  - Counter-width helper function.
- Sub-module pulser_channel: one channel's debounce, edge detect, pulse FSM and repeat logic. The top level only generates NUM_CH instances.

Test Plan:
- DEBOUNCE=4, PULSE_WIDTH=1, rising: trigger 0->1 held 20 cycles -> level and pulse rise after the 4th high sample; pulse high exactly 1 cycle; no further pulse while held.
- Glitch: trigger high 3 cycles then low, DEBOUNCE=4 -> level, pulse and overrun stay 0.
- EDGE_MODE=2, PULSE_WIDTH=3: press, hold 10, release -> two 3-cycle pulses, one at each level change. EDGE_MODE=1 -> only the release pulse.
- Overrun: EDGE_MODE=2, DEBOUNCE=1, PULSE_WIDTH=4, trigger high 2 cycles then low -> one 4-cycle pulse and overrun=1. Same-cycle set and clear_overrun -> overrun stays 1; clear alone -> 0 next cycle.
- Reset mid-pulse (PULSE_WIDTH=8, reset at pulse cycle 3) -> pulse=0 next edge. Trigger held through reset release -> new pulse DEBOUNCE cycles later.
- With MULTI_PULSER_REPEAT_EN, REPEAT_DELAY=20, REPEAT_PERIOD=5, hold 40 cycles -> pulses at t0, t0+20, +25, +30, +35; release stops further pulses. Channel 1 is unaffected by channel 0 activity throughout.
